// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//
// Instruction-fetch front end. It issues sequential fetch requests to the
// instruction ROM over a request/acknowledge handshake and buffers the
// returned instructions in a DEPTH-entry queue. The queue head is presented
// to decode. Branch redirects from decode flush the queue, keeping one
// delay-slot instruction when DELAY_SLOT=1.
//
// Ports
//   clk                      clock; all state changes on its rising edge
//   rst                      asynchronous active-low reset
//   rom_ce_o                 fetch request valid (a request is outstanding)
//   rom_addr_o               outstanding fetch address, held until ack
//   rom_data_i               returned instruction, valid with rom_ack_i
//   rom_ack_i                completes the outstanding request
//   stall_i                  decode stalled; head is not consumed
//   branch_flag_i            decode requests a redirect
//   branch_target_address_i  redirect target
//   id_pc_o                  head PC, 0 when queue empty
//   id_inst_o                head instruction, 0 (NOP) when queue empty
//   id_valid_o               queue non-empty
//   count_o                  queue occupancy
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | no request outstanding
// S_BUSY    | request outstanding, its data will be queued
// S_DISCARD | request outstanding, its data will be dropped

module if_fetch_queue #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          INST_W     = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          DELAY_SLOT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      rom_ce_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [INST_W-1:0]         rom_data_i,
  input  logic                      rom_ack_i,
  input  logic                      stall_i,
  input  logic                      branch_flag_i,
  input  logic [ADDR_W-1:0]         branch_target_address_i,
  output logic [ADDR_W-1:0]         id_pc_o,
  output logic [INST_W-1:0]         id_inst_o,
  output logic                      id_valid_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned       PTR_W   = $clog2(DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  pc_mem   [DEPTH];
  logic [INST_W-1:0]  inst_mem [DEPTH];

  logic               id_valid;
  logic               pop;
  logic               br;
  logic               keep_one;
  logic               drop_outstanding;
  logic               push;
  logic               can_start;
  logic               issue;
  logic [PTR_W-1:0]   rd_base;
  logic [PTR_W-1:0]   wr_base;
  logic [CNT_W-1:0]   keep_cnt;
  logic [ADDR_W-1:0]  issue_addr;

  assign id_valid = (count_q != '0);
  assign pop      = id_valid & ~stall_i;
  assign br       = branch_flag_i & pop;

  // With a delay slot and at least two entries, entry 1 is the slot and the
  // outstanding request is younger than it, so it goes. With a single entry
  // the outstanding request is the slot itself and must be kept.
  assign keep_one         = (DELAY_SLOT != 0) && (count_q >= CNT_W'(2));
  assign drop_outstanding = (DELAY_SLOT == 0) || (count_q >= CNT_W'(2));

  assign push      = (state_q == S_BUSY) & rom_ack_i & ~(br & drop_outstanding);
  assign can_start = (state_q == S_IDLE) | rom_ack_i;

  // Queue bookkeeping. A redirect rebuilds the tail from the post-pop head,
  // so the new write pointer sits just past whatever is kept.
  always_comb begin
    rd_base = rd_ptr_q + PTR_W'(pop);
    if (br) begin
      keep_cnt = CNT_W'(keep_one);
      wr_base  = rd_base + PTR_W'(keep_one);
    end else begin
      keep_cnt = count_q - CNT_W'(pop);
      wr_base  = wr_ptr_q;
    end
    count_d  = keep_cnt + CNT_W'(push);
    wr_ptr_d = wr_base + PTR_W'(push);
    rd_ptr_d = rd_base;

    // The issue check uses next-cycle occupancy, which guarantees a free slot
    // for the data of the request being started.
    issue      = can_start && (count_d < DEPTH_C);
    issue_addr = br ? branch_target_address_i : fpc_q;

    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    if (issue) begin
      req_addr_d = issue_addr;
      fpc_d      = issue_addr + PC_STEP;
    end else if (br) begin
      fpc_d = branch_target_address_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        state_d = issue ? S_BUSY : S_IDLE;
      end
      S_BUSY: begin
        if (rom_ack_i) begin
          state_d = issue ? S_BUSY : S_IDLE;
        end else if (br && drop_outstanding) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (rom_ack_i) begin
          state_d = issue ? S_BUSY : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fpc_q      <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_base]   <= req_addr_q;
      inst_mem[wr_base] <= rom_data_i;
    end
  end

  assign rom_ce_o   = (state_q != S_IDLE);
  assign rom_addr_o = req_addr_q;
  assign id_valid_o = id_valid;
  assign id_pc_o    = id_valid ? pc_mem[rd_ptr_q] : '0;
  assign id_inst_o  = id_valid ? inst_mem[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule
